// File: rtl/kb_bus_ctrl_pkg.sv
// Shared definitions for the keyboard bus controller: register offsets,
// register bit positions, FSM state encoding and the STATUS word builder.
package kb_bus_ctrl_pkg;

    // Register window offsets (bus_addr[1:0])
    localparam logic [1:0] KB_OFF_STATUS = 2'd0;
    localparam logic [1:0] KB_OFF_DATA   = 2'd1;
    localparam logic [1:0] KB_OFF_CTRL   = 2'd2;
    localparam logic [1:0] KB_OFF_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int unsigned KB_ST_KBS_BIT  = 0;
    localparam int unsigned KB_ST_FULL_BIT = 1;
    localparam int unsigned KB_ST_OVF_BIT  = 2;
    localparam int unsigned KB_ST_TMO_BIT  = 3;

    // CTRL register bit positions
    localparam int unsigned KB_CTRL_BLOCK_BIT = 0;
    localparam int unsigned KB_CTRL_CLEAR_BIT = 1;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_POP      = 2'd2,
        ST_ACK      = 2'd3
    } kb_state_e;

    // Assemble the 4-bit STATUS word from its flag sources
    function automatic logic [3:0] kb_status_word(input logic tmo, input logic ovf,
                                                  input logic full, input logic kbs);
        logic [3:0] w;
        w = '0;
        w[KB_ST_TMO_BIT]  = tmo;
        w[KB_ST_OVF_BIT]  = ovf;
        w[KB_ST_FULL_BIT] = full;
        w[KB_ST_KBS_BIT]  = kbs;
        return w;
    endfunction

endpackage

// File: rtl/kb_bus_ctrl_wait_timer.sv
// Blocking-read wait timer: synchronous clear, count enable and a
// terminal-count flag raised when the count reaches TIMEOUT_CYC-1.
module kb_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/kb_bus_ctrl.sv
// Memory-mapped controller between the CPU data bus and the keyboard unit.
// Decodes a 4-register window, issues single-cycle pop/flush strobes, keeps
// sticky overflow/timeout flags and optionally stalls DATA reads.
module kb_bus_ctrl
    import kb_bus_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 64,
    parameter int unsigned       DATA_W      = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(64'hF000),
    parameter int unsigned       TIMEOUT_CYC = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rd,
    input  logic              bus_wr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
    input  logic              KB_status,
    input  logic [6:0]        KB_data,
    input  logic              buf_full,
    output logic              KB_read_en,
    output logic              KB_clear
);
    kb_state_e         state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              pop_q, pop_d;
    logic              clear_q, clear_d;
    logic              block_q, block_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic              full_q;
    logic              tmr_clr, tmr_en, tmr_tc;
    logic              hit;
    logic [1:0]        off;
    logic              unused_wdata;

    assign hit = (bus_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign off = bus_addr[1:0];
    assign unused_wdata = ^bus_wdata[DATA_W-1:2];

    kb_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .tc_o  (tmr_tc)
    );

    // Next-state, read-data and strobe decode; strobes are registered so
    // ack/pop/clear are asserted during the POP/ACK state that follows.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        pop_d   = 1'b0;
        clear_d = 1'b0;
        block_d = block_q;
        tmo_d   = tmo_q;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit && bus_rd) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    unique case (off)
                        KB_OFF_STATUS: rdata_d = DATA_W'(kb_status_word(tmo_q, ovf_q, buf_full, KB_status));
                        KB_OFF_CTRL:   rdata_d = DATA_W'(block_q);
                        KB_OFF_RSVD:   rdata_d = '0;
                        default: begin
                            if (KB_status) begin
                                rdata_d = DATA_W'(KB_data);
                                state_d = ST_POP;
                                pop_d   = 1'b1;
                            end else if (!block_q) begin
                                rdata_d = '0;
                            end else begin
                                state_d = ST_WAIT_KEY;
                                ack_d   = 1'b0;
                            end
                        end
                    endcase
                end else if (hit && bus_wr) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    rdata_d = '0;
                    if (off == KB_OFF_CTRL) begin
                        block_d = bus_wdata[KB_CTRL_BLOCK_BIT];
                        clear_d = bus_wdata[KB_CTRL_CLEAR_BIT];
                    end
                end
            end
            ST_WAIT_KEY: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                // A key arriving on the timeout cycle still wins
                if (KB_status) begin
                    rdata_d = DATA_W'(KB_data);
                    state_d = ST_POP;
                    pop_d   = 1'b1;
                    ack_d   = 1'b1;
                end else if (tmr_tc) begin
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear_d) begin
            tmo_d = 1'b0;
        end
    end

    // Overflow flag: a buf_full rising edge sets it and beats a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        if (buf_full && !full_q) begin
            ovf_d = 1'b1;
        end else if (clear_d) begin
            ovf_d = 1'b0;
        end
    end

    // State, flags and registered bus/keyboard outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            pop_q   <= 1'b0;
            clear_q <= 1'b0;
            block_q <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            pop_q   <= pop_d;
            clear_q <= clear_d;
            block_q <= block_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            full_q  <= buf_full;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_ack    = ack_q;
    assign KB_read_en = pop_q;
    assign KB_clear   = clear_q;

endmodule

// File: tb/tb_kb_bus_ctrl.sv
// Directed bench for kb_bus_ctrl: a vector table of single transactions
// plus hand-written blocking-read, flag and reset sequences.
module tb_kb_bus_ctrl;

    localparam logic [63:0] BASE = 64'hF000;
    localparam int MAXC = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] bus_addr = '0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [63:0] bus_wdata = '0;
    logic [63:0] bus_rdata;
    logic        bus_ack;
    logic        KB_status = 1'b0;
    logic [6:0]  KB_data = '0;
    logic        buf_full = 1'b0;
    logic        KB_read_en;
    logic        KB_clear;

    int n_chk = 0;
    int n_fail = 0;

    kb_bus_ctrl #(
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (bus_addr),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .KB_status  (KB_status),
        .KB_data    (KB_data),
        .buf_full   (buf_full),
        .KB_read_en (KB_read_en),
        .KB_clear   (KB_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  off;
        logic [63:0] wdata;
        logic        kbs;
        logic [6:0]  kbd;
        logic        chk_rdata;
        logic [63:0] exp_rdata;
        int          exp_pops;
        int          exp_clears;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one request; optionally raise KB_status with key after key_at cycles.
    task automatic do_txn(input logic rd, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input int key_at, input logic [6:0] key,
                          output logic [63:0] rdata, output int lat, output int pops,
                          output int clears, output bit acked);
        @(negedge clk);
        bus_rd = rd;
        bus_wr = wr;
        bus_addr = addr;
        bus_wdata = wdata;
        acked = 1'b0;
        lat = 0;
        pops = 0;
        clears = 0;
        rdata = '0;
        for (int c = 1; c <= MAXC && !acked; c++) begin
            @(posedge clk);
            #1;
            pops += int'(KB_read_en);
            clears += int'(KB_clear);
            if (bus_ack) begin
                acked = 1'b1;
                lat = c;
                rdata = bus_rdata;
                bus_rd = 1'b0;
                bus_wr = 1'b0;
            end else if (c == key_at) begin
                KB_status = 1'b1;
                KB_data = key;
            end
        end
        bus_rd = 1'b0;
        bus_wr = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            pops += int'(KB_read_en);
            clears += int'(KB_clear);
        end
    endtask

    task automatic rd_status(input string nm, input logic [63:0] exp);
        logic [63:0] rd_v;
        int lat, pops, clears;
        bit acked;
        do_txn(1'b1, 1'b0, BASE, '0, 0, '0, rd_v, lat, pops, clears, acked);
        chk({nm, " ack"}, 64'(acked), 64'd1);
        chk(nm, rd_v, exp);
    endtask

    task automatic wr_ctrl(input string nm, input logic [63:0] wd, input int exp_clears);
        logic [63:0] rd_v;
        int lat, pops, clears;
        bit acked;
        do_txn(1'b0, 1'b1, BASE + 64'd2, wd, 0, '0, rd_v, lat, pops, clears, acked);
        chk({nm, " ack"}, 64'(acked), 64'd1);
        chk({nm, " clears"}, 64'(clears), 64'(exp_clears));
    endtask

    initial begin
        logic [63:0] rd_v;
        int lat, pops, clears;
        bit acked;

        //            rd wr off   wdata   kbs kbd    chk rdata      pops clr
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 64'h0,  1'b0, 7'h00, 1'b1, 64'h0,  0, 0};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 64'h0,  1'b1, 7'h41, 1'b1, 64'h41, 1, 0};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 64'h0,  1'b0, 7'h55, 1'b1, 64'h0,  0, 0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 64'h0,  1'b1, 7'h22, 1'b1, 64'h1,  0, 0};
        vecs[4]  = '{1'b1, 1'b0, 2'd2, 64'h0,  1'b0, 7'h00, 1'b1, 64'h0,  0, 0};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 64'h1,  1'b0, 7'h00, 1'b0, 64'h0,  0, 0};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 64'h0,  1'b0, 7'h00, 1'b1, 64'h1,  0, 0};
        vecs[7]  = '{1'b1, 1'b0, 2'd3, 64'h0,  1'b1, 7'h33, 1'b1, 64'h0,  0, 0};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 64'h0,  1'b0, 7'h00, 1'b1, 64'h1,  0, 0};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 64'h0,  1'b0, 7'h00, 1'b1, 64'h1,  0, 0};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 64'hFF, 1'b0, 7'h00, 1'b0, 64'h0,  0, 0};
        vecs[11] = '{1'b0, 1'b1, 2'd0, 64'hF,  1'b0, 7'h00, 1'b0, 64'h0,  0, 0};
        vecs[12] = '{1'b1, 1'b0, 2'd1, 64'h0,  1'b1, 7'h7F, 1'b1, 64'h7F, 1, 0};
        vecs[13] = '{1'b0, 1'b1, 2'd2, 64'h0,  1'b0, 7'h00, 1'b0, 64'h0,  0, 0};
        vecs[14] = '{1'b1, 1'b0, 2'd2, 64'h0,  1'b0, 7'h00, 1'b1, 64'h0,  0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst ack", 64'(bus_ack), 64'd0);
        chk("rst rdata", bus_rdata, 64'd0);
        chk("rst read_en", 64'(KB_read_en), 64'd0);
        chk("rst clear", 64'(KB_clear), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst ack", 64'(bus_ack), 64'd0);

        // Vector table: single-cycle-latency transactions
        foreach (vecs[i]) begin
            KB_status = vecs[i].kbs;
            KB_data = vecs[i].kbd;
            do_txn(vecs[i].rd, vecs[i].wr, BASE + 64'(vecs[i].off), vecs[i].wdata, 0, '0,
                   rd_v, lat, pops, clears, acked);
            chk($sformatf("vec%0d ack", i), 64'(acked), 64'd1);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd1);
            if (vecs[i].chk_rdata) chk($sformatf("vec%0d rdata", i), rd_v, vecs[i].exp_rdata);
            chk($sformatf("vec%0d pops", i), 64'(pops), 64'(vecs[i].exp_pops));
            chk($sformatf("vec%0d clears", i), 64'(clears), 64'(vecs[i].exp_clears));
        end
        KB_status = 1'b0;

        // Blocking read, key arrives 5 cycles in
        wr_ctrl("blk on", 64'h1, 0);
        do_txn(1'b1, 1'b0, BASE + 64'd1, '0, 5, 7'h7A, rd_v, lat, pops, clears, acked);
        KB_status = 1'b0;
        chk("key5 ack", 64'(acked), 64'd1);
        chk("key5 latency", 64'(lat), 64'd6);
        chk("key5 rdata", rd_v, 64'h7A);
        chk("key5 pops", 64'(pops), 64'd1);
        rd_status("key5 status", 64'h0);

        // Key arriving on the timeout cycle wins
        do_txn(1'b1, 1'b0, BASE + 64'd1, '0, 16, 7'h31, rd_v, lat, pops, clears, acked);
        KB_status = 1'b0;
        chk("keyTC ack", 64'(acked), 64'd1);
        chk("keyTC latency", 64'(lat), 64'd17);
        chk("keyTC rdata", rd_v, 64'h31);
        chk("keyTC pops", 64'(pops), 64'd1);
        rd_status("keyTC status", 64'h0);

        // Overflow flag and flush
        buf_full = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rd_status("ovf status", 64'h6);
        wr_ctrl("flush", 64'h2, 1);
        buf_full = 1'b0;
        rd_status("flushed status", 64'h0);
        buf_full = 1'b1;
        wr_ctrl("flush+rise", 64'h2, 1);
        rd_status("set-wins status", 64'h6);
        buf_full = 1'b0;
        wr_ctrl("flush2", 64'h2, 1);
        rd_status("flushed2 status", 64'h0);

        // Blocking read timeout
        wr_ctrl("blk on2", 64'h1, 0);
        do_txn(1'b1, 1'b0, BASE + 64'd1, '0, 0, '0, rd_v, lat, pops, clears, acked);
        chk("tmo ack", 64'(acked), 64'd1);
        chk("tmo latency", 64'(lat), 64'd17);
        chk("tmo rdata", rd_v, 64'h0);
        chk("tmo pops", 64'(pops), 64'd0);
        rd_status("tmo status", 64'h8);
        wr_ctrl("tmo clear", 64'h3, 1);
        rd_status("tmo cleared status", 64'h0);

        // Reset while waiting for a key
        @(negedge clk);
        bus_addr = BASE + 64'd1;
        bus_rd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst ack", 64'(bus_ack), 64'd0);
        chk("midrst rdata", bus_rdata, 64'd0);
        chk("midrst read_en", 64'(KB_read_en), 64'd0);
        acked = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus_ack) acked = 1'b1;
            if (c == 2) bus_rd = 1'b0;
            if (c == 3) rst_n = 1'b1;
        end
        chk("midrst no ack", 64'(acked), 64'd0);
        do_txn(1'b1, 1'b0, BASE + 64'd2, '0, 0, '0, rd_v, lat, pops, clears, acked);
        chk("midrst ctrl ack", 64'(acked), 64'd1);
        chk("midrst block_en", rd_v, 64'h0);

        // Out-of-window requests are never acked
        do_txn(1'b1, 1'b0, BASE + 64'd8, '0, 0, '0, rd_v, lat, pops, clears, acked);
        chk("miss rd ack", 64'(acked), 64'd0);
        do_txn(1'b0, 1'b1, BASE + 64'd8, 64'h3, 0, '0, rd_v, lat, pops, clears, acked);
        chk("miss wr ack", 64'(acked), 64'd0);
        chk("miss wr clears", 64'(clears), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
